// File: rtl/adc_capture_pktgen.sv
// Multi-channel ADC capture packetiser: arms on cfg_start, optional lead-in idle,
// then serialises NUM_CH-wide sample sets into SOP/EOP-framed packets with gaps.
module adc_capture_pktgen #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 18,
   parameter int LEN_W  = 16,
   parameter int GAP_W  = 8,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic                     cfg_stop,
   input  logic                     cfg_self_test,
   input  logic [LEN_W-1:0]         cfg_idle_len,
   input  logic [LEN_W-1:0]         cfg_pkt_len,
   input  logic [LEN_W-1:0]         cfg_num_pkt,
   input  logic [GAP_W-1:0]         cfg_gap,
   input  logic [NUM_CH*DATA_W-1:0] adc_data,
   input  logic                     adc_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_valid,
   output logic                     out_sop,
   output logic                     out_eop,
   output logic                     busy,
   output logic                     done,
   output logic                     ovf
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {IDLE, LEAD, DATA, GAP} state_t;
   state_t state, state_nx;

   logic [LEN_W-1:0]  cnt, cnt_nx;
   logic              self_test_q;
   logic [LEN_W-1:0]  pkt_len_q, num_pkt_q;
   logic [GAP_W-1:0]  gap_q;
   logic [LEN_W-1:0]  set_cnt, pkt_cnt, pkt_cnt_inc, set_idx;
   logic [DATA_W-1:0] sample_cnt;
   logic              stop_pend, set_last;
   logic              free, eop_now, adv, accept, first_set, is_last, pkt_end, stop_empty;
   logic [CH_W-1:0]   ch_nx;
   logic [DATA_W-1:0] word_c [NUM_CH];
   logic [DATA_W-1:0] sh_p0 [0:NUM_CH];

   // The output register is "busy" until it shows the last channel of a set.
   assign free        = !out_valid || (out_ch == LAST_CH);
   assign adv         = out_valid && (out_ch != LAST_CH);
   assign eop_now     = out_valid && out_eop;
   assign ch_nx       = out_ch + CH_W'(1);
   assign pkt_cnt_inc = (&pkt_cnt) ? pkt_cnt : pkt_cnt + LEN_W'(1);
   assign first_set   = eop_now || (set_cnt == '0);
   assign set_idx     = first_set ? LEN_W'(1) : set_cnt + LEN_W'(1);
   assign is_last     = (set_idx == pkt_len_q);
   assign pkt_end     = eop_now && (stop_pend || cfg_stop ||
                        ((num_pkt_q != '0) && (pkt_cnt_inc == num_pkt_q)));
   assign stop_empty  = cfg_stop && (set_cnt == '0) && !eop_now;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++)
         word_c[c] = self_test_q ? sample_cnt + DATA_W'(c) : adc_data[c*DATA_W +: DATA_W];
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      accept   = 1'b0;
      case (state)
         IDLE: if (cfg_start) begin
            if (cfg_idle_len != '0) begin
               state_nx = LEAD;
               cnt_nx   = cfg_idle_len;
            end else begin
               state_nx = DATA;
            end
         end
         LEAD, GAP: begin
            if (cfg_stop)                 state_nx = IDLE;
            else if (cnt <= LEN_W'(1))    state_nx = DATA;
            else                          cnt_nx   = cnt - LEN_W'(1);
         end
         DATA: begin
            if (pkt_end || stop_empty) begin
               state_nx = IDLE;
            end else if (eop_now && (gap_q != '0)) begin
               state_nx = GAP;
               cnt_nx   = LEN_W'(gap_q);
            end else begin
               accept = free && (self_test_q || adc_valid);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Control stage: state, counters, latched configuration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         self_test_q <= 1'b0;
         pkt_len_q   <= '0;
         num_pkt_q   <= '0;
         gap_q       <= '0;
         set_cnt     <= '0;
         pkt_cnt     <= '0;
         sample_cnt  <= '0;
         stop_pend   <= 1'b0;
         set_last    <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         busy  <= (state_nx != IDLE);
         done  <= (state != IDLE) && (state_nx == IDLE);
         if (state == IDLE && cfg_start) begin
            self_test_q <= cfg_self_test;
            pkt_len_q   <= (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
            num_pkt_q   <= cfg_num_pkt;
            gap_q       <= cfg_gap;
            set_cnt     <= '0;
            pkt_cnt     <= '0;
            sample_cnt  <= '0;
            stop_pend   <= 1'b0;
            set_last    <= 1'b0;
            ovf         <= 1'b0;
         end else begin
            if (accept) begin
               set_cnt  <= set_idx;
               set_last <= is_last;
               if (self_test_q) sample_cnt <= sample_cnt + DATA_W'(1);
            end else if (eop_now) begin
               set_cnt <= '0;
            end
            if (eop_now) pkt_cnt <= pkt_cnt_inc;
            if (state == DATA && cfg_stop && state_nx == DATA) stop_pend <= 1'b1;
            if (state == DATA && !self_test_q && adc_valid && !free) ovf <= 1'b1;
         end
      end
   end

   // Sample buffer stage: holds the channels not yet serialised
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < NUM_CH; c++) sh_p0[c] <= word_c[c];
         sh_p0[NUM_CH] <= '0;
      end else if (adv) begin
         for (int i = 0; i < NUM_CH; i++) sh_p0[i] <= sh_p0[i+1];
      end
   end

   // Output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end else if (accept) begin
         out_data  <= word_c[0];
         out_ch    <= '0;
         out_valid <= 1'b1;
         out_sop   <= first_set;
         out_eop   <= is_last && (NUM_CH == 1);
      end else if (adv) begin
         out_data  <= sh_p0[1];
         out_ch    <= ch_nx;
         out_sop   <= 1'b0;
         out_eop   <= set_last && (ch_nx == LAST_CH);
      end else begin
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_capture_pktgen.sv
// Directed bench for adc_capture_pktgen (NUM_CH=4): framing, timing, overflow,
// stop handling, start-while-busy and asynchronous reset.
module tb_adc_capture_pktgen;
   localparam int NUM_CH = 4, DATA_W = 18, LEN_W = 16, GAP_W = 8, CH_W = 2;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     cfg_start = 1'b0, cfg_stop = 1'b0, cfg_self_test = 1'b0;
   logic [LEN_W-1:0]         cfg_idle_len = '0, cfg_pkt_len = '0, cfg_num_pkt = '0;
   logic [GAP_W-1:0]         cfg_gap = '0;
   logic [NUM_CH*DATA_W-1:0] adc_data = '0;
   logic                     adc_valid = 1'b0;
   logic [DATA_W-1:0]        out_data;
   logic [CH_W-1:0]          out_ch;
   logic                     out_valid, out_sop, out_eop, busy, done, ovf;

   int tests = 0;
   int fails = 0;

   adc_capture_pktgen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .cfg_self_test(cfg_self_test), .cfg_idle_len(cfg_idle_len), .cfg_pkt_len(cfg_pkt_len),
      .cfg_num_pkt(cfg_num_pkt), .cfg_gap(cfg_gap), .adc_data(adc_data), .adc_valid(adc_valid),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_sop(out_sop),
      .out_eop(out_eop), .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns in the cycle after the start pulse (relative cycle 1).
   task automatic do_start(input logic st, input int idle, input int plen, input int npkt, input int gap);
      cfg_self_test = st;
      cfg_idle_len  = LEN_W'(idle);
      cfg_pkt_len   = LEN_W'(plen);
      cfg_num_pkt   = LEN_W'(npkt);
      cfg_gap       = GAP_W'(gap);
      cfg_start     = 1'b1;
      step();
      cfg_start     = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      tests++;
      if ({out_data, out_ch, out_valid, out_sop, out_eop, busy, done, ovf} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got %h want 0", {out_data, out_ch, out_valid, out_sop, out_eop, busy, done, ovf});
      end
      #3 rst = 1'b0;
      step();
   endtask

   task automatic test_self_test_packets();
      int exp_d[16] = '{0,1,2,3,1,2,3,4,2,3,4,5,3,4,5,6};
      int n = 0, done_cyc = -1;
      do_start(1'b1, 3, 2, 2, 5);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL st_busy_rise: got %b want 1", busy); end
      for (int c = 1; c <= 34; c++) begin
         if (out_valid === 1'b1) begin
            int exp_c = (n < 8) ? 5 + n : 11 + n;
            tests++;
            if (n >= 16 || c != exp_c || int'(out_data) != exp_d[n % 16] || int'(out_ch) != n % 4 ||
                out_sop !== (n % 8 == 0) || out_eop !== (n % 8 == 7)) begin
               fails++;
               $display("FAIL st_word%0d: got cyc=%0d d=%0d ch=%0d sop=%b eop=%b want cyc=%0d d=%0d ch=%0d",
                        n, c, out_data, out_ch, out_sop, out_eop, exp_c, exp_d[n % 16], n % 4);
            end
            n++;
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         step();
      end
      tests++;
      if (n != 16) begin fails++; $display("FAIL st_word_count: got %0d want 16", n); end
      tests++;
      if (done_cyc != 27) begin fails++; $display("FAIL st_done_cycle: got %0d want 27", done_cyc); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL st_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_normal_mode();
      logic [NUM_CH*DATA_W-1:0] set_a = {18'h3A003, 18'h2A002, 18'h1A001, 18'h0A000};
      logic [NUM_CH*DATA_W-1:0] set_b = {18'h3B0C3, 18'h2B0C2, 18'h1B0C1, 18'h0B0C0};
      int exp_d[8] = '{'h0A000, 'h1A001, 'h2A002, 'h3A003, 'h0B0C0, 'h1B0C1, 'h2B0C2, 'h3B0C3};
      int n = 0, done_cyc = -1;
      do_start(1'b0, 0, 2, 1, 0);
      for (int c = 1; c <= 14; c++) begin
         if (out_valid === 1'b1) begin
            tests++;
            if (n >= 8 || c != 2 + n || int'(out_data) != exp_d[n % 8] || int'(out_ch) != n % 4 ||
                out_sop !== (n == 0) || out_eop !== (n == 7)) begin
               fails++;
               $display("FAIL nm_word%0d: got cyc=%0d d=%h ch=%0d sop=%b eop=%b want cyc=%0d d=%h ch=%0d",
                        n, c, out_data, out_ch, out_sop, out_eop, 2 + n, exp_d[n % 8], n % 4);
            end
            n++;
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         adc_valid = (c == 1 || c == 5);
         adc_data  = (c == 1) ? set_a : set_b;
         step();
      end
      adc_valid = 1'b0;
      tests++;
      if (n != 8 || done_cyc != 10) begin
         fails++;
         $display("FAIL nm_count_done: got n=%0d done=%0d want n=8 done=10", n, done_cyc);
      end
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL nm_ovf: got %b want 0", ovf); end
   endtask

   task automatic test_overflow();
      logic [NUM_CH*DATA_W-1:0] set_c = {18'h00C33, 18'h00C22, 18'h00C11, 18'h00C00};
      logic [NUM_CH*DATA_W-1:0] set_d = {18'h0DDD3, 18'h0DDD2, 18'h0DDD1, 18'h0DDD0};
      int exp_d[4] = '{'h00C00, 'h00C11, 'h00C22, 'h00C33};
      int n = 0;
      do_start(1'b0, 0, 1, 1, 0);
      for (int c = 1; c <= 10; c++) begin
         if (out_valid === 1'b1) begin
            tests++;
            if (n >= 4 || c != 2 + n || int'(out_data) != exp_d[n % 4] || out_eop !== (n == 3)) begin
               fails++;
               $display("FAIL ov_word%0d: got cyc=%0d d=%h eop=%b want cyc=%0d d=%h", n, c, out_data, out_eop, 2 + n, exp_d[n % 4]);
            end
            n++;
         end
         if (c == 3) begin
            tests++;
            if (ovf !== 1'b1) begin fails++; $display("FAIL ov_set: got %b want 1", ovf); end
         end
         adc_valid = (c == 1 || c == 2);
         adc_data  = (c == 1) ? set_c : set_d;
         step();
      end
      adc_valid = 1'b0;
      tests++;
      if (ovf !== 1'b1 || busy !== 1'b0 || n != 4) begin
         fails++;
         $display("FAIL ov_sticky: got ovf=%b busy=%b n=%0d want ovf=1 busy=0 n=4", ovf, busy, n);
      end
   endtask

   task automatic test_start_while_busy();
      int n = 0, first_c = -1, eop_c = -1, done_cyc = -1;
      do_start(1'b1, 3, 1, 1, 0);
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL sb_ovf_clear: got %b want 0", ovf); end
      for (int c = 1; c <= 12; c++) begin
         if (out_valid === 1'b1) begin
            if (first_c < 0) first_c = c;
            if (out_eop === 1'b1) eop_c = c;
            tests++;
            if (n >= 4 || int'(out_data) != n) begin
               fails++;
               $display("FAIL sb_word%0d: got %0d want %0d", n, out_data, n);
            end
            n++;
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (c == 2) begin
            cfg_start = 1'b1; cfg_pkt_len = 16'd3; cfg_idle_len = 16'd0; cfg_num_pkt = 16'd2;
         end else begin
            cfg_start = 1'b0;
         end
         step();
      end
      tests++;
      if (first_c != 5 || eop_c != 8 || done_cyc != 9 || n != 4) begin
         fails++;
         $display("FAIL sb_ignored: got first=%0d eop=%0d done=%0d n=%0d want 5 8 9 4", first_c, eop_c, done_cyc, n);
      end
   endtask

   task automatic test_stop_lead();
      int nv = 0, done_cyc = -1;
      logic busy_c2 = 1'b0, busy_c3 = 1'b1;
      do_start(1'b1, 5, 1, 1, 0);
      for (int c = 1; c <= 8; c++) begin
         if (out_valid === 1'b1) nv++;
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (c == 2) busy_c2 = busy;
         if (c == 3) busy_c3 = busy;
         cfg_stop = (c == 2);
         step();
      end
      tests++;
      if (done_cyc != 3 || busy_c2 !== 1'b1 || busy_c3 !== 1'b0 || nv != 0) begin
         fails++;
         $display("FAIL sl_stop: got done=%0d busy2=%b busy3=%b nvalid=%0d want 3 1 0 0", done_cyc, busy_c2, busy_c3, nv);
      end
   endtask

   task automatic test_stop_continuous();
      int n = 0, sops = 0, eops = 0, done_cyc = -1, last_d = -1, eop1 = -1, eop2 = -1, w12 = -1;
      do_start(1'b1, 0, 3, 0, 2);
      for (int c = 1; c <= 40; c++) begin
         if (out_valid === 1'b1) begin
            if (out_sop === 1'b1) sops++;
            if (out_eop === 1'b1) begin
               eops++;
               if (eops == 1) eop1 = c; else eop2 = c;
            end
            if (n == 12) w12 = int'(out_data);
            last_d = int'(out_data);
            n++;
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         cfg_stop = (c == 20);
         step();
      end
      tests++;
      if (sops != 2 || eops != 2 || n != 24) begin
         fails++;
         $display("FAIL sc_framing: got sop=%0d eop=%0d n=%0d want 2 2 24", sops, eops, n);
      end
      tests++;
      if (eop1 != 13 || eop2 != 28 || done_cyc != 29) begin
         fails++;
         $display("FAIL sc_timing: got eop1=%0d eop2=%0d done=%0d want 13 28 29", eop1, eop2, done_cyc);
      end
      tests++;
      if (w12 != 3 || last_d != 8 || busy !== 1'b0) begin
         fails++;
         $display("FAIL sc_data: got w12=%0d last=%0d busy=%b want 3 8 0", w12, last_d, busy);
      end
   endtask

   task automatic test_reset_mid();
      int exp_d[8] = '{0,1,2,3,1,2,3,4};
      int n = 0, done_cyc = -1;
      do_start(1'b1, 0, 2, 1, 0);
      step();
      step();
      tests++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL rm_midpacket: got valid=%b want 1", out_valid); end
      #3 rst = 1'b1;
      #1;
      tests++;
      if ({out_data, out_ch, out_valid, out_sop, out_eop, busy, done, ovf} !== '0) begin
         fails++;
         $display("FAIL rm_async_clear: got %h want 0", {out_data, out_ch, out_valid, out_sop, out_eop, busy, done, ovf});
      end
      @(posedge clk);
      #3 rst = 1'b0;
      step();
      do_start(1'b1, 0, 2, 1, 0);
      for (int c = 1; c <= 12; c++) begin
         if (out_valid === 1'b1) begin
            tests++;
            if (n >= 8 || c != 2 + n || int'(out_data) != exp_d[n % 8] || int'(out_ch) != n % 4 ||
                out_sop !== (n == 0) || out_eop !== (n == 7)) begin
               fails++;
               $display("FAIL rm_word%0d: got cyc=%0d d=%0d ch=%0d sop=%b eop=%b want cyc=%0d d=%0d",
                        n, c, out_data, out_ch, out_sop, out_eop, 2 + n, exp_d[n % 8]);
            end
            n++;
         end
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         step();
      end
      tests++;
      if (n != 8 || done_cyc != 10) begin
         fails++;
         $display("FAIL rm_restart: got n=%0d done=%0d want 8 10", n, done_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_self_test_packets();
      test_normal_mode();
      test_overflow();
      test_start_while_busy();
      test_stop_lead();
      test_stop_continuous();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
